// File: rtl/noc_injection_arbiter_pkg.sv
// Shared types and width helpers for the endpoint injection arbiter.
// Width functions match the mesh side so client indices and credit counters agree.
package noc_injection_arbiter_pkg;

    localparam int unsigned NUM_CLIENTS_DEF  = 4;
    localparam int unsigned DEST_WIDTH_DEF   = 4;
    localparam int unsigned FLIT_WIDTH_DEF   = 128;
    localparam int unsigned CREDIT_COUNT_DEF = 4;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Bits needed to index n items (never less than one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to hold a counter ranging over 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/noc_injection_arbiter_if.sv
// Client-side request bus and mesh-side injection port of the arbiter.
// slave = arbiter view, master = clients plus router view.
interface noc_injection_arbiter_if #(
    parameter int unsigned NUM_CLIENTS = 4,
    parameter int unsigned DEST_WIDTH  = 4,
    parameter int unsigned FLIT_WIDTH  = 128
);

    logic [NUM_CLIENTS-1:0]                 client_valid;
    logic [NUM_CLIENTS-1:0][FLIT_WIDTH-1:0] client_data;
    logic [NUM_CLIENTS-1:0][DEST_WIDTH-1:0] client_dest;
    logic [NUM_CLIENTS-1:0]                 client_is_tail;
    logic [NUM_CLIENTS-1:0]                 client_ready;

    logic [FLIT_WIDTH-1:0]                  data_out;
    logic [DEST_WIDTH-1:0]                  dest_out;
    logic                                   is_tail_out;
    logic                                   send_out;
    logic                                   credit_in;
    logic                                   err_credit_ovf;

    modport slave (
        input  client_valid,
        input  client_data,
        input  client_dest,
        input  client_is_tail,
        output client_ready,
        output data_out,
        output dest_out,
        output is_tail_out,
        output send_out,
        input  credit_in,
        output err_credit_ovf
    );

    modport master (
        output client_valid,
        output client_data,
        output client_dest,
        output client_is_tail,
        input  client_ready,
        input  data_out,
        input  dest_out,
        input  is_tail_out,
        input  send_out,
        output credit_in,
        input  err_credit_ovf
    );

endinterface

// File: rtl/noc_injection_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module noc_injection_arbiter_rr_arbiter
    import noc_injection_arbiter_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_c,
    output logic [IW-1:0] grant_idx_c,
    output logic          any_grant_c
);

    // ptr + k stays below 2*N, so one extra bit and a single subtract give the modulo.
    always_comb begin
        logic [IW:0] cand;
        grant_c     = '0;
        grant_idx_c = '0;
        any_grant_c = 1'b0;
        cand        = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!any_grant_c && req[cand[IW-1:0]]) begin
                any_grant_c               = 1'b1;
                grant_idx_c               = cand[IW-1:0];
                grant_c[cand[IW-1:0]]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_injection_arbiter.sv
// Shares one mesh injection port among local clients: packet-granular round robin,
// credit flow control toward the router buffer, registered flit output stage.
module noc_injection_arbiter
    import noc_injection_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS  = NUM_CLIENTS_DEF,
    parameter int unsigned DEST_WIDTH   = DEST_WIDTH_DEF,
    parameter int unsigned FLIT_WIDTH   = FLIT_WIDTH_DEF,
    parameter int unsigned CREDIT_COUNT = CREDIT_COUNT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    noc_injection_arbiter_if.slave   bus
);

    localparam int unsigned IW = idx_width(NUM_CLIENTS);
    localparam int unsigned CW = cnt_width(CREDIT_COUNT);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDIT_COUNT);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_CLIENTS - 1);

    arb_state_t             state_q, state_d;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]          owner_q, owner_d;
    logic [CW-1:0]          credits_q, credits_d;
    logic                   err_credit_ovf_q, err_credit_ovf_d;
    logic [FLIT_WIDTH-1:0]  data_q, data_d;
    logic [DEST_WIDTH-1:0]  dest_q, dest_d;
    logic                   is_tail_q, is_tail_d;
    logic                   send_q, send_d;

    logic [NUM_CLIENTS-1:0] arb_grant_c;
    logic [IW-1:0]          arb_idx_c;
    logic                   arb_any_c;

    logic [NUM_CLIENTS-1:0] pick_vec_c;
    logic [IW-1:0]          pick_idx_c;
    logic                   pick_valid_c;
    logic                   accept_c;
    logic [NUM_CLIENTS-1:0] ready_c;

    noc_injection_arbiter_rr_arbiter #(
        .N (NUM_CLIENTS)
    ) u_rr_arbiter (
        .req         (bus.client_valid),
        .ptr         (rr_ptr_q),
        .grant_c     (arb_grant_c),
        .grant_idx_c (arb_idx_c),
        .any_grant_c (arb_any_c)
    );

    // Next-state, credit and output-stage logic.
    always_comb begin
        state_d          = state_q;
        rr_ptr_d         = rr_ptr_q;
        owner_d          = owner_q;
        credits_d        = credits_q;
        err_credit_ovf_d = err_credit_ovf_q;
        data_d           = data_q;
        dest_d           = dest_q;
        is_tail_d        = is_tail_q;
        send_d           = 1'b0;
        pick_vec_c       = '0;
        pick_idx_c       = owner_q;
        pick_valid_c     = 1'b0;
        ready_c          = '0;

        // A locked owner keeps the port even while it bubbles; nobody else may cut in.
        if (state_q == ARB_IDLE) begin
            pick_vec_c   = arb_grant_c;
            pick_idx_c   = arb_idx_c;
            pick_valid_c = arb_any_c;
        end else begin
            pick_vec_c[owner_q] = bus.client_valid[owner_q];
            pick_valid_c        = bus.client_valid[owner_q];
        end

        accept_c = pick_valid_c && (credits_q != '0) && !rst;

        if (accept_c) begin
            ready_c   = pick_vec_c;
            data_d    = bus.client_data[pick_idx_c];
            dest_d    = bus.client_dest[pick_idx_c];
            is_tail_d = bus.client_is_tail[pick_idx_c];
            send_d    = 1'b1;
            if (bus.client_is_tail[pick_idx_c]) begin
                state_d  = ARB_IDLE;
                rr_ptr_d = (pick_idx_c == LAST_IDX) ? '0 : pick_idx_c + IW'(1);
            end else begin
                state_d = ARB_LOCKED;
                owner_d = pick_idx_c;
            end
        end

        // Credit is spent at accept so the flit sitting in the output register is covered.
        if (accept_c && !bus.credit_in) begin
            credits_d = credits_q - CW'(1);
        end else if (!accept_c && bus.credit_in) begin
            if (credits_q == CREDIT_MAX) begin
                err_credit_ovf_d = 1'b1;
            end else begin
                credits_d = credits_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ARB_IDLE;
            rr_ptr_q         <= '0;
            owner_q          <= '0;
            credits_q        <= CREDIT_MAX;
            err_credit_ovf_q <= 1'b0;
            data_q           <= '0;
            dest_q           <= '0;
            is_tail_q        <= 1'b0;
            send_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            rr_ptr_q         <= rr_ptr_d;
            owner_q          <= owner_d;
            credits_q        <= credits_d;
            err_credit_ovf_q <= err_credit_ovf_d;
            data_q           <= data_d;
            dest_q           <= dest_d;
            is_tail_q        <= is_tail_d;
            send_q           <= send_d;
        end
    end

    assign bus.client_ready   = ready_c;
    assign bus.data_out       = data_q;
    assign bus.dest_out       = dest_q;
    assign bus.is_tail_out    = is_tail_q;
    assign bus.send_out       = send_q;
    assign bus.err_credit_ovf = err_credit_ovf_q;

endmodule

// File: tb/tb_noc_injection_arbiter.sv
// Scoreboard bench for noc_injection_arbiter: a packet-level reference model predicts
// grants and queues expected flits; an independent monitor checks the mesh-side output.
`timescale 1ns/1ps
module tb_noc_injection_arbiter;
    import noc_injection_arbiter_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 4;
    localparam int unsigned FW = 128;
    localparam int unsigned CC = 4;

    typedef struct packed {
        logic [FW-1:0] data;
        logic [DW-1:0] dest;
        logic          tail;
    } flit_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    noc_injection_arbiter_if #(.NUM_CLIENTS(N), .DEST_WIDTH(DW), .FLIT_WIDTH(FW)) bus ();

    noc_injection_arbiter #(
        .NUM_CLIENTS (N),
        .DEST_WIDTH  (DW),
        .FLIT_WIDTH  (FW),
        .CREDIT_COUNT(CC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    flit_t cq[N][$];      // per-client packets still to be offered
    int    gap[N];        // forced valid-low cycles per client
    int    bubble_pct;
    bit    auto_credit;
    int    ret_dly_min, ret_dly_max;
    bit    man_credit;
    int    cyc;
    int    ret_q[$];
    flit_t sb[$];
    int    tail_src[$];
    int    sent_cnt;
    int    n_checks, n_fail;
    int    m_owner, m_prio, m_credits;
    bit    m_ovf;
    int    cur_src;
    bit    in_pkt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_wide(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Client and router emulation, driven just after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            logic v;
            v = 1'b0;
            if (gap[i] > 0) gap[i]--;
            else if (cq[i].size() != 0) v = ($urandom_range(99) >= bubble_pct);
            bus.client_valid[i] = v;
            if (cq[i].size() != 0) begin
                bus.client_data[i]    = cq[i][0].data;
                bus.client_dest[i]    = cq[i][0].dest;
                bus.client_is_tail[i] = cq[i][0].tail;
            end
        end
        bus.credit_in = 1'b0;
        if (man_credit) begin
            bus.credit_in = 1'b1;
            man_credit    = 1'b0;
        end else if (auto_credit && ret_q.size() != 0 && ret_q[0] <= cyc) begin
            void'(ret_q.pop_front());
            bus.credit_in = 1'b1;
        end
    end

    // Reference model: owner/priority/credit count derived from the arbitration rules.
    always @(negedge clk) begin
        if (rst) begin
            m_owner   = -1;
            m_prio    = 0;
            m_credits = CC;
            m_ovf     = 1'b0;
        end else begin
            logic [N-1:0] pred;
            int pick;
            bit acc;
            pred = '0;
            pick = -1;
            if (m_credits > 0) begin
                if (m_owner >= 0) begin
                    if (bus.client_valid[m_owner]) pick = m_owner;
                end else begin
                    for (int k = 0; k < N; k++) begin
                        int c;
                        c = (m_prio + k) % N;
                        if (pick < 0 && bus.client_valid[c]) pick = c;
                    end
                end
            end
            if (pick >= 0) pred[pick] = 1'b1;
            check("client_ready", 64'(bus.client_ready), 64'(pred));
            check("err_credit_ovf", 64'(bus.err_credit_ovf), 64'(m_ovf));
            acc = (pick >= 0);
            if (acc) begin
                flit_t f;
                f = cq[pick].pop_front();
                sb.push_back(f);
                if (f.tail) begin
                    m_owner = -1;
                    m_prio  = (pick + 1) % N;
                end else begin
                    m_owner = pick;
                end
            end
            if (acc && !bus.credit_in) m_credits--;
            else if (!acc && bus.credit_in) begin
                if (m_credits == CC) m_ovf = 1'b1;
                else m_credits++;
            end
        end
    end

    // Output monitor: each accepted flit must appear exactly one cycle later.
    always @(posedge clk) begin
        #2;
        if (rst) begin
            sb.delete();
            ret_q.delete();
            in_pkt = 1'b0;
        end else begin
            check("send_out", 64'(bus.send_out), (sb.size() != 0) ? 64'd1 : 64'd0);
            if (sb.size() != 0) begin
                flit_t e;
                int src;
                e = sb.pop_front();
                if (bus.send_out) begin
                    check_wide("flit", 256'({bus.data_out, bus.dest_out, bus.is_tail_out}), 256'(e));
                    sent_cnt++;
                    src = int'(bus.data_out[FW-1 -: 8]);
                    if (in_pkt) check("pkt_interleave", 64'(src), 64'(cur_src));
                    cur_src = src;
                    in_pkt  = !bus.is_tail_out;
                    if (bus.is_tail_out) tail_src.push_back(src);
                    if (auto_credit) ret_q.push_back(cyc + int'($urandom_range(ret_dly_max, ret_dly_min)));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #4;
    endtask

    task automatic clear_tb();
        for (int i = 0; i < N; i++) begin
            cq[i].delete();
            gap[i] = 0;
        end
        man_credit       = 1'b0;
        auto_credit      = 1'b0;
        bubble_pct       = 0;
        tail_src.delete();
        sent_cnt         = 0;
        bus.client_valid = '0;
        bus.credit_in    = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        clear_tb();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
    endtask

    task automatic add_pkt(input int c, input int len, input int p);
        for (int f = 0; f < len; f++) begin
            flit_t fl;
            fl.data = {$urandom, $urandom, $urandom, $urandom};
            fl.data[FW-1 -: 24] = {8'(c), 8'(p), 8'(f)};
            fl.dest = DW'($urandom);
            fl.tail = (f == len - 1);
            cq[c].push_back(fl);
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (cq[i].size() != 0) return 1'b0;
        return (sb.size() == 0);
    endfunction

    task automatic wait_drain(input int max_cyc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (all_empty()) begin
                done = 1'b1;
                break;
            end
            step(1);
        end
        step(2);
        check("drain_timeout", 64'(done), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int total;
        n_checks    = 0;
        n_fail      = 0;
        cyc         = 0;
        ret_dly_min = 2;
        ret_dly_max = 2;
        bus.client_data    = '0;
        bus.client_dest    = '0;
        bus.client_is_tail = '0;
        rst = 1'b1;
        clear_tb();
        step(3);
        check("rst_send_out", 64'(bus.send_out), 64'd0);
        check("rst_is_tail", 64'(bus.is_tail_out), 64'd0);
        check("rst_data", 64'(bus.data_out[63:0]), 64'd0);
        check("rst_dest", 64'(bus.dest_out), 64'd0);
        check("rst_err", 64'(bus.err_credit_ovf), 64'd0);
        check("rst_ready", 64'(bus.client_ready), 64'd0);
        #3 rst = 1'b0;

        // Single 3-flit packet with no credit return, then credits run dry at one.
        do_reset();
        add_pkt(0, 3, 0);
        step(6);
        check("t1_sent", 64'(sent_cnt), 64'd3);
        check("t1_tails", 64'(tail_src.size()), 64'd1);
        add_pkt(0, 2, 1);
        step(6);
        check("t1_credit_limit", 64'(sent_cnt), 64'd4);
        check("t1_ready_starved", 64'(bus.client_ready[0]), 64'd0);

        // Three clients, two 2-flit packets each, credits looped back after 2 cycles.
        do_reset();
        auto_credit = 1'b1;
        ret_dly_min = 2;
        ret_dly_max = 2;
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 3; c++) add_pkt(c, 2, p);
        wait_drain(200);
        check("t2_tails", 64'(tail_src.size()), 64'd6);
        for (int i = 0; i < 6; i++)
            if (i < tail_src.size()) check("t2_order", 64'(tail_src[i]), 64'(i % 3));

        // Credit stall on a 6-flit packet, then a single returned credit.
        do_reset();
        add_pkt(1, 6, 0);
        step(10);
        check("t3_stall_sent", 64'(sent_cnt), 64'd4);
        check("t3_stall_ready", 64'(bus.client_ready[1]), 64'd0);
        man_credit = 1'b1;
        step(6);
        check("t3_one_more", 64'(sent_cnt), 64'd5);
        check("t3_stall_again", 64'(bus.client_ready[1]), 64'd0);

        // Accept and credit return in the same cycle leave the count at two.
        do_reset();
        add_pkt(0, 2, 0);
        step(6);
        add_pkt(0, 1, 1);
        man_credit = 1'b1;
        step(6);
        check("t4_sent_a", 64'(sent_cnt), 64'd3);
        add_pkt(0, 4, 2);
        step(8);
        check("t4_sent_b", 64'(sent_cnt), 64'd5);

        // Credit returned while full sets the sticky overflow flag.
        do_reset();
        check("ovf_clear", 64'(bus.err_credit_ovf), 64'd0);
        man_credit = 1'b1;
        step(2);
        check("ovf_set", 64'(bus.err_credit_ovf), 64'd1);
        step(5);
        check("ovf_sticky", 64'(bus.err_credit_ovf), 64'd1);
        do_reset();
        check("ovf_rst", 64'(bus.err_credit_ovf), 64'd0);

        // Lock hold: owner bubbles for 5 cycles, a competing client must wait for the tail.
        do_reset();
        auto_credit = 1'b1;
        ret_dly_min = 1;
        ret_dly_max = 3;
        add_pkt(2, 3, 0);
        for (int i = 0; i < 20 && cq[2].size() == 3; i++) step(1);
        check("t5_head_taken", 64'(cq[2].size() < 3), 64'd1);
        gap[2] = 5;
        add_pkt(0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("t5_lock_ready0", 64'(bus.client_ready[0]), 64'd0);
        end
        wait_drain(60);
        check("t5_tails", 64'(tail_src.size()), 64'd2);
        if (tail_src.size() == 2) begin
            check("t5_first", 64'(tail_src[0]), 64'd2);
            check("t5_second", 64'(tail_src[1]), 64'd0);
        end

        // Asynchronous reset between edges in the middle of a packet.
        do_reset();
        auto_credit = 1'b1;
        add_pkt(1, 4, 0);
        for (int i = 0; i < 20 && cq[1].size() > 2; i++) step(1);
        check("t6_pre_send", 64'(bus.send_out), 64'd1);
        rst = 1'b1;
        clear_tb();
        #1;
        check("t6_send_zero", 64'(bus.send_out), 64'd0);
        check("t6_data_zero", 64'(bus.data_out[63:0] | bus.data_out[127:64]), 64'd0);
        check("t6_dest_zero", 64'(bus.dest_out), 64'd0);
        check("t6_tail_zero", 64'(bus.is_tail_out), 64'd0);
        check("t6_ready_zero", 64'(bus.client_ready), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        add_pkt(3, 1, 0);
        add_pkt(0, 4, 1);
        step(8);
        check("t6_credits_full", 64'(sent_cnt), 64'd4);
        check("t6_rr_restart", 64'(tail_src.size() != 0 ? tail_src[0] : 99), 64'd0);
        check("t6_c3_starved", 64'(bus.client_ready[3]), 64'd0);

        // Randomized traffic on all clients with bubbles and jittered credit return.
        do_reset();
        auto_credit = 1'b1;
        ret_dly_min = 1;
        ret_dly_max = 6;
        bubble_pct  = 25;
        total = 0;
        for (int p = 0; p < 12; p++)
            for (int c = 0; c < N; c++) begin
                int len;
                len = int'($urandom_range(5, 1));
                add_pkt(c, len, p);
                total += len;
            end
        wait_drain(5000);
        check("t7_sent", 64'(sent_cnt), 64'(total));
        check("t7_tails", 64'(tail_src.size()), 64'(N * 12));
        bubble_pct = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
